// File: rtl/noc_vortex_noc2buf_pkg.sv
// -----------------------------------------------------------------------------
// noc_vortex_noc2buf_pkg
// Shared definitions for the Piton NoC -> Vortex scratch-buffer front-end:
// message-type codes, header/payload field positions, size encodings, FSM
// state type and small address helpers.
// Optional feature macro used by the top: VORTEX_NOC2BUF_ERRCNT_EN.
// -----------------------------------------------------------------------------
package noc_vortex_noc2buf_pkg;

    // Request / ack message types
    localparam logic [7:0] NC_LOAD_REQ      = 8'd14;
    localparam logic [7:0] NC_STORE_REQ     = 8'd15;
    localparam logic [7:0] NC_LOAD_MEM_ACK  = 8'd26;
    localparam logic [7:0] NC_STORE_MEM_ACK = 8'd27;

    // Header flit field LSBs (all fields 8 bits wide)
    localparam int HDR_LEN_LSB  = 22;
    localparam int HDR_TYPE_LSB = 14;
    localparam int HDR_MSHR_LSB = 6;

    // Address flit: size code in [62:60], address in [39:0]
    localparam int ADDR_SIZE_LSB = 60;

    // Source flit: chip/x/y/fbits in [63:30]
    localparam int SRC_LSB = 30;
    localparam int SRC_W   = 34;

    // Size codes
    localparam logic [2:0] SZ_1B = 3'd1;
    localparam logic [2:0] SZ_2B = 3'd2;
    localparam logic [2:0] SZ_4B = 3'd3;
    localparam logic [2:0] SZ_8B = 3'd4;

    typedef enum logic [3:0] {
        S_HDR,
        S_ADDR,
        S_SRC,
        S_DATA,
        S_DRAIN,
        S_ACC,
        S_RD,
        S_RHDR,
        S_RDATA
    } state_e;

    function automatic logic size_bad(input logic [2:0] sz);
        return (sz == 3'd0) || (sz > SZ_8B);
    endfunction

    // Misaligned requests are aligned down to the access size.
    function automatic logic [31:0] align_addr(input logic [31:0] a, input logic [2:0] sz);
        logic [31:0] r;
        case (sz)
            SZ_2B:   r = {a[31:1], 1'b0};
            SZ_4B:   r = {a[31:2], 2'b00};
            SZ_8B:   r = {a[31:3], 3'b000};
            default: r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/noc_vortex_noc2buf_resp_fmt.sv
// -----------------------------------------------------------------------------
// noc_vortex_resp_fmt
// Combinational response formatter: builds the ack header flit and the
// lane-selected, replicated load data flit.
// Ports:
//   src_i      in  34  requester chip/x/y/fbits (becomes ack destination)
//   is_load_i  in  1   1 = load ack (len 1), 0 = store ack (len 0)
//   mshr_i     in  8   mshr id echoed back
//   rdata_i    in  64  captured buffer word
//   addr_lo_i  in  3   request address bits [2:0] (lane select)
//   size_i     in  3   size code 1..4
//   hdr_o      out 64  ack header flit
//   data_o     out 64  replicated load data flit
// -----------------------------------------------------------------------------
module noc_vortex_resp_fmt
    import noc_vortex_noc2buf_pkg::*;
(
    input  logic [SRC_W-1:0] src_i,
    input  logic             is_load_i,
    input  logic [7:0]       mshr_i,
    input  logic [63:0]      rdata_i,
    input  logic [2:0]       addr_lo_i,
    input  logic [2:0]       size_i,
    output logic [63:0]      hdr_o,
    output logic [63:0]      data_o
);

    logic [7:0]  b8;
    logic [15:0] h16;
    logic [31:0] w32;

    always_comb begin
        hdr_o = {src_i,
                 is_load_i ? 8'd1 : 8'd0,
                 is_load_i ? NC_LOAD_MEM_ACK : NC_STORE_MEM_ACK,
                 mshr_i,
                 6'd0};
    end

    // Little-endian byte lanes within the 64-bit buffer word.
    always_comb begin
        b8  = rdata_i[{addr_lo_i, 3'b000} +: 8];
        h16 = rdata_i[{addr_lo_i[2:1], 4'b0000} +: 16];
        w32 = rdata_i[{addr_lo_i[2], 5'b00000} +: 32];
        case (size_i)
            SZ_1B:   data_o = {8{b8}};
            SZ_2B:   data_o = {4{h16}};
            SZ_4B:   data_o = {2{w32}};
            SZ_8B:   data_o = rdata_i;
            default: data_o = 64'd0;
        endcase
    end

endmodule

// File: rtl/noc_vortex_noc2buf.sv
// -----------------------------------------------------------------------------
// noc_vortex_noc2buf
// Piton NoC request front-end for the Vortex bridge scratch buffer. Turns each
// NC load/store packet into one buffer access and returns the ack packet.
// Ports:
//   clk, rst (async, active-high)
//   noc_in_val/noc_in_data/noc_in_rdy     request flit channel
//   noc_out_val/noc_out_data/noc_out_rdy  response flit channel
//   buf_addr_o/buf_data_o/buf_ce_o/buf_we_o/buf_data_sz_o  buffer request
//   buf_data_i   buffer read data, valid 1 cycle after ce with we=0
//   busy_o       high whenever the FSM is not waiting for a header
//   err_cnt_o    malformed-packet counter (only with VORTEX_NOC2BUF_ERRCNT_EN)
// Macro: VORTEX_NOC2BUF_ERRCNT_EN adds err_cnt_o and its saturating counter.
// -----------------------------------------------------------------------------
module noc_vortex_noc2buf
    import noc_vortex_noc2buf_pkg::*;
#(
    parameter logic [31:0] BUF_ADDR_MASK = 32'h0000_0FFF,
    parameter logic [7:0]  MAX_DRAIN     = 8'd8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        noc_in_val,
    input  logic [63:0] noc_in_data,
    output logic        noc_in_rdy,
    output logic        noc_out_val,
    output logic [63:0] noc_out_data,
    input  logic        noc_out_rdy,
    output logic [31:0] buf_addr_o,
    output logic [63:0] buf_data_o,
    output logic        buf_ce_o,
    output logic        buf_we_o,
    output logic [1:0]  buf_data_sz_o,
    input  logic [63:0] buf_data_i,
    output logic        busy_o
`ifdef VORTEX_NOC2BUF_ERRCNT_EN
    ,
    output logic [15:0] err_cnt_o
`endif
);

    state_e             state_q;
    logic [7:0]         rem_q;
    logic [7:0]         drain_q;
    logic               is_load_q;
    logic               is_store_q;
    logic               mal_q;
    logic [7:0]         mshr_q;
    logic [SRC_W-1:0]   src_q;
    logic [31:0]        addr_q;
    logic [2:0]         size_q;
    logic [63:0]        sdata_q;
    logic [63:0]        rdata_q;
    logic               err_pulse_q;

    logic               ce_q;
    logic               we_q;
    logic [31:0]        baddr_q;
    logic [63:0]        bdata_q;
    logic [1:0]         bsz_q;
    logic               oval_q;
    logic [63:0]        odata_q;

    logic               fire;
    logic               in_payload;
    logic [7:0]         rem_dec;
    logic [31:0]        addr_d;
    logic [2:0]         size_d;
    logic [63:0]        sdata_d;
    logic               mal_d;
    logic               pkt_end;
    logic               drain_abort;
    state_e             follow_d;
    logic [7:0]         hdr_len;
    logic [7:0]         hdr_type;
    logic               hdr_load;
    logic               hdr_store;

    logic [63:0]        fmt_hdr;
    logic [63:0]        fmt_data;

    noc_vortex_resp_fmt u_fmt (
        .src_i     (src_q),
        .is_load_i (is_load_q),
        .mshr_i    (mshr_q),
        .rdata_i   (rdata_q),
        .addr_lo_i (addr_q[2:0]),
        .size_i    (size_q),
        .hdr_o     (fmt_hdr),
        .data_o    (fmt_data)
    );

    // Input is accepted only while collecting a packet; never during access/response.
    assign noc_in_rdy = ~rst & ((state_q == S_HDR)  | (state_q == S_ADDR) |
                                (state_q == S_SRC)  | (state_q == S_DATA) |
                                (state_q == S_DRAIN));
    assign busy_o        = (state_q != S_HDR);
    assign buf_ce_o      = ce_q;
    assign buf_we_o      = we_q;
    assign buf_addr_o    = baddr_q;
    assign buf_data_o    = bdata_q;
    assign buf_data_sz_o = bsz_q;
    assign noc_out_val   = oval_q;
    assign noc_out_data  = odata_q;

    always_comb begin
        fire       = noc_in_val & noc_in_rdy;
        in_payload = (state_q == S_ADDR) | (state_q == S_SRC) |
                     (state_q == S_DATA) | (state_q == S_DRAIN);
        rem_dec    = rem_q - 8'd1;
        hdr_len    = noc_in_data[HDR_LEN_LSB +: 8];
        hdr_type   = noc_in_data[HDR_TYPE_LSB +: 8];
        hdr_load   = (hdr_type == NC_LOAD_REQ);
        hdr_store  = (hdr_type == NC_STORE_REQ);
        // Values as they will be once the current flit is absorbed, so the
        // access can be issued on the same edge that takes the last flit.
        addr_d     = (state_q == S_ADDR) ? noc_in_data[31:0] : addr_q;
        size_d     = (state_q == S_ADDR) ? noc_in_data[ADDR_SIZE_LSB +: 3] : size_q;
        sdata_d    = (state_q == S_DATA) ? noc_in_data : sdata_q;
        mal_d      = mal_q | ((state_q == S_ADDR) & size_bad(noc_in_data[ADDR_SIZE_LSB +: 3]));
        pkt_end    = fire & in_payload & (rem_dec == 8'd0);
        drain_abort = fire & (state_q == S_DRAIN) & (rem_dec != 8'd0) &
                      ((drain_q + 8'd1) >= MAX_DRAIN);
        case (state_q)
            S_ADDR:  follow_d = S_SRC;
            S_SRC:   follow_d = is_store_q ? S_DATA : S_DRAIN;
            default: follow_d = S_DRAIN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_HDR;
            rem_q       <= '0;
            drain_q     <= '0;
            is_load_q   <= 1'b0;
            is_store_q  <= 1'b0;
            mal_q       <= 1'b0;
            mshr_q      <= '0;
            src_q       <= '0;
            addr_q      <= '0;
            size_q      <= '0;
            sdata_q     <= '0;
            rdata_q     <= '0;
            err_pulse_q <= 1'b0;
            ce_q        <= 1'b0;
            we_q        <= 1'b0;
            baddr_q     <= '0;
            bdata_q     <= '0;
            bsz_q       <= '0;
            oval_q      <= 1'b0;
            odata_q     <= '0;
        end else begin
            ce_q        <= 1'b0;
            err_pulse_q <= 1'b0;
            case (state_q)
                S_HDR: begin
                    if (fire) begin
                        mshr_q     <= noc_in_data[HDR_MSHR_LSB +: 8];
                        is_load_q  <= hdr_load;
                        is_store_q <= hdr_store;
                        mal_q      <= ~((hdr_load & (hdr_len >= 8'd2)) |
                                        (hdr_store & (hdr_len >= 8'd3)));
                        rem_q      <= hdr_len;
                        src_q      <= '0;
                        addr_q     <= '0;
                        size_q     <= '0;
                        sdata_q    <= '0;
                        rdata_q    <= '0;
                        drain_q    <= '0;
                        if (hdr_len == 8'd0) begin
                            err_pulse_q <= 1'b1;
                        end else begin
                            state_q <= S_ADDR;
                        end
                    end
                end
                S_ADDR, S_SRC, S_DATA, S_DRAIN: begin
                    if (fire) begin
                        rem_q <= rem_dec;
                        if (state_q == S_ADDR) begin
                            addr_q <= addr_d;
                            size_q <= size_d;
                            mal_q  <= mal_d;
                        end
                        if (state_q == S_SRC) begin
                            src_q <= noc_in_data[SRC_LSB +: SRC_W];
                        end
                        if (state_q == S_DATA) begin
                            sdata_q <= sdata_d;
                        end
                        if (state_q == S_DRAIN) begin
                            drain_q <= drain_q + 8'd1;
                        end
                        if (pkt_end) begin
                            err_pulse_q <= mal_d;
                            if (is_load_q | is_store_q) begin
                                state_q <= S_ACC;
                                if (!mal_d) begin
                                    ce_q    <= 1'b1;
                                    we_q    <= is_store_q;
                                    baddr_q <= align_addr(addr_d, size_d) & BUF_ADDR_MASK;
                                    bsz_q   <= 2'(size_d - 3'd1);
                                    bdata_q <= sdata_d;
                                end
                            end else begin
                                // Unknown type: swallow silently, no ack.
                                state_q <= S_HDR;
                            end
                        end else if (drain_abort) begin
                            err_pulse_q <= 1'b1;
                            state_q     <= S_HDR;
                        end else begin
                            state_q <= follow_d;
                        end
                    end
                end
                S_ACC: begin
                    if (is_load_q) begin
                        state_q <= S_RD;
                    end else begin
                        state_q <= S_RHDR;
                        oval_q  <= 1'b1;
                        odata_q <= fmt_hdr;
                    end
                end
                S_RD: begin
                    // Malformed loads never issued ce, so return zero data.
                    rdata_q <= mal_q ? 64'd0 : buf_data_i;
                    state_q <= S_RHDR;
                    oval_q  <= 1'b1;
                    odata_q <= fmt_hdr;
                end
                S_RHDR: begin
                    if (noc_out_rdy) begin
                        if (is_load_q) begin
                            state_q <= S_RDATA;
                            odata_q <= fmt_data;
                        end else begin
                            state_q <= S_HDR;
                            oval_q  <= 1'b0;
                            odata_q <= '0;
                        end
                    end
                end
                S_RDATA: begin
                    if (noc_out_rdy) begin
                        state_q <= S_HDR;
                        oval_q  <= 1'b0;
                        odata_q <= '0;
                    end
                end
                default: state_q <= S_HDR;
            endcase
        end
    end

`ifdef VORTEX_NOC2BUF_ERRCNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (err_pulse_q && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    logic unused_err_pulse;
    assign unused_err_pulse = err_pulse_q;
`endif

endmodule

// File: tb/tb_noc_vortex_noc2buf.sv
module tb_noc_vortex_noc2buf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        noc_in_val = 1'b0;
    logic [63:0] noc_in_data = '0;
    logic        noc_in_rdy;
    logic        noc_out_val;
    logic [63:0] noc_out_data;
    logic        noc_out_rdy = 1'b1;
    logic [31:0] buf_addr_o;
    logic [63:0] buf_data_o;
    logic        buf_ce_o;
    logic        buf_we_o;
    logic [1:0]  buf_data_sz_o;
    logic [63:0] buf_data_i = '0;
    logic        busy_o;
`ifdef VORTEX_NOC2BUF_ERRCNT_EN
    logic [15:0] err_cnt;
`endif

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    noc_vortex_noc2buf dut (
        .clk           (clk),
        .rst           (rst),
        .noc_in_val    (noc_in_val),
        .noc_in_data   (noc_in_data),
        .noc_in_rdy    (noc_in_rdy),
        .noc_out_val   (noc_out_val),
        .noc_out_data  (noc_out_data),
        .noc_out_rdy   (noc_out_rdy),
        .buf_addr_o    (buf_addr_o),
        .buf_data_o    (buf_data_o),
        .buf_ce_o      (buf_ce_o),
        .buf_we_o      (buf_we_o),
        .buf_data_sz_o (buf_data_sz_o),
        .buf_data_i    (buf_data_i),
        .busy_o        (busy_o)
`ifdef VORTEX_NOC2BUF_ERRCNT_EN
        ,
        .err_cnt_o     (err_cnt)
`endif
    );

    typedef struct {
        string       name;
        logic [7:0]  mtype;
        logic [7:0]  len;
        int          nfl;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [33:0] src;
        logic [7:0]  mshr;
        logic [63:0] sdata;
        logic [63:0] rword;
        bit          exp_ce;
        bit          exp_we;
        logic [31:0] exp_addr;
        logic [1:0]  exp_sz;
        bit          exp_resp;
        bit          exp_rdata;
        logic [63:0] exp_data;
        bit          exp_mal;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic add(input string nm, input logic [7:0] mtype, input logic [7:0] len,
                       input int nfl, input logic [31:0] addr, input logic [2:0] size,
                       input logic [63:0] sdata, input logic [63:0] rword,
                       input bit ece, input bit ewe, input logic [31:0] eaddr,
                       input logic [1:0] esz, input bit eresp, input logic [63:0] edata,
                       input bit mal);
        vec_t v;
        v.name = nm; v.mtype = mtype; v.len = len; v.nfl = nfl; v.addr = addr;
        v.size = size; v.sdata = sdata; v.rword = rword;
        v.src  = 34'h2_0000_0000 | (34'h111 * 34'(vq.size() + 1));
        v.mshr = 8'h40 + 8'(vq.size());
        v.exp_ce = ece; v.exp_we = ewe; v.exp_addr = eaddr; v.exp_sz = esz;
        v.exp_resp = eresp; v.exp_rdata = eresp && (mtype == 8'd14);
        v.exp_data = edata; v.exp_mal = mal;
        vq.push_back(v);
    endtask

    function automatic logic [63:0] hdr_flit(input vec_t v);
        return {34'd0, v.len, v.mtype, v.mshr, 6'd0};
    endfunction

    function automatic logic [63:0] flit_of(input vec_t v, input int i);
        logic [63:0] f;
        case (i)
            0: f = {1'b0, v.size, 28'd0, v.addr};
            1: f = {v.src, 30'd0};
            2: f = (v.mtype == 8'd15) ? v.sdata : (64'hD0D0_0000_0000_0000 | 64'(i));
            default: f = 64'hD0D0_0000_0000_0000 | 64'(i);
        endcase
        return f;
    endfunction

    function automatic logic [63:0] exp_hdr(input vec_t v);
        logic is_ld;
        is_ld = (v.mtype == 8'd14);
        return {v.src, is_ld ? 8'd1 : 8'd0, is_ld ? 8'd26 : 8'd27, v.mshr, 6'd0};
    endfunction

    // Present one flit; returns once it has been taken (or the bound expires).
    task automatic send_flit(input logic [63:0] d, output bit ok);
        ok = 1'b0;
        noc_in_val  = 1'b1;
        noc_in_data = d;
        for (int i = 0; i < 60 && !ok; i++) begin
            if (noc_in_rdy) ok = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic send_pkt(input vec_t v, output bit ok);
        bit f_ok;
        send_flit(hdr_flit(v), ok);
        for (int i = 0; i < v.nfl; i++) begin
            send_flit(flit_of(v, i), f_ok);
            ok &= f_ok;
        end
    endtask

    task automatic run_vec(input vec_t v);
        bit          ok;
        int          ce_n;
        bit          seen;
        logic        c_we;
        logic [31:0] c_addr;
        logic [1:0]  c_sz;
        logic [63:0] c_data;
`ifdef VORTEX_NOC2BUF_ERRCNT_EN
        logic [15:0] err0;
        err0 = err_cnt;
`endif
        ce_n = 0; seen = 1'b0; c_we = 1'b0; c_addr = '0; c_sz = '0; c_data = '0;
        buf_data_i  = v.rword;
        noc_out_rdy = 1'b1;
        send_pkt(v, ok);
        noc_in_val = 1'b0;
        chk({v.name, ".accept"}, 64'(ok), 64'd1);
        for (int c = 0; c < 40 && !seen; c++) begin
            if (buf_ce_o) begin
                ce_n++;
                c_we = buf_we_o; c_addr = buf_addr_o; c_sz = buf_data_sz_o; c_data = buf_data_o;
            end
            if (noc_out_val) seen = 1'b1;
            else @(negedge clk);
        end
        chk({v.name, ".ce_count"}, 64'(ce_n), v.exp_ce ? 64'd1 : 64'd0);
        if (v.exp_ce) begin
            chk({v.name, ".we"}, 64'(c_we), 64'(v.exp_we));
            chk({v.name, ".addr"}, 64'(c_addr), 64'(v.exp_addr));
            chk({v.name, ".sz"}, 64'(c_sz), 64'(v.exp_sz));
            if (v.exp_we) chk({v.name, ".wdata"}, c_data, v.sdata);
        end
        chk({v.name, ".resp"}, 64'(seen), 64'(v.exp_resp));
        if (seen) begin
            chk({v.name, ".hdr"}, noc_out_data, exp_hdr(v));
            @(negedge clk);
            if (v.exp_rdata) begin
                chk({v.name, ".rval"}, 64'(noc_out_val), 64'd1);
                chk({v.name, ".rdata"}, noc_out_data, v.exp_data);
                @(negedge clk);
            end
            chk({v.name, ".out_idle"}, 64'(noc_out_val), 64'd0);
        end
        chk({v.name, ".busy_end"}, 64'(busy_o), 64'd0);
`ifdef VORTEX_NOC2BUF_ERRCNT_EN
        chk({v.name, ".errcnt"}, 64'(err_cnt - err0), 64'(v.exp_mal));
`endif
    endtask

    initial begin
        bit          ok;
        vec_t        v;
        logic [63:0] h0;
        bit          stable;
        int          ce_we[$];
        logic [63:0] outs[$];

        //   name        type  len nfl addr          size sdata                  rword                  ce we eaddr        sz   resp edata                  mal
        add("st8",      8'd15, 8'd3, 3, 32'h0000_1008, 3'd4, 64'h1122334455667788, 64'd0,                1, 1, 32'h008, 2'd3, 1, 64'd0,                0);
        add("ld1",      8'd14, 8'd2, 2, 32'h0000_0005, 3'd1, 64'd0,                64'h0000AB0000000000, 1, 0, 32'h005, 2'd0, 1, 64'hABABABABABABABAB, 0);
        add("ld2",      8'd14, 8'd2, 2, 32'h0000_0FF6, 3'd2, 64'd0,                64'h123456789ABCDEF0, 1, 0, 32'hFF6, 2'd1, 1, 64'h1234123412341234, 0);
        add("ld4_mis",  8'd14, 8'd2, 2, 32'h0000_2007, 3'd3, 64'd0,                64'hCAFEBABEDEADBEEF, 1, 0, 32'h004, 2'd2, 1, 64'hCAFEBABECAFEBABE, 0);
        add("ld8_mis",  8'd14, 8'd2, 2, 32'h0000_3003, 3'd4, 64'd0,                64'h0F1E2D3C4B5A6978, 1, 0, 32'h000, 2'd3, 1, 64'h0F1E2D3C4B5A6978, 0);
        add("st2_mis",  8'd15, 8'd3, 3, 32'h0000_0123, 3'd2, 64'h000000000000BEEF, 64'd0,                1, 1, 32'h122, 2'd1, 1, 64'd0,                0);
        add("st_sz6",   8'd15, 8'd3, 3, 32'h0000_0100, 3'd6, 64'h5555AAAA5555AAAA, 64'd0,                0, 0, 32'h0,   2'd0, 1, 64'd0,                1);
        add("ld_sz0",   8'd14, 8'd2, 2, 32'h0000_0200, 3'd0, 64'd0,                64'hFFFFFFFFFFFFFFFF, 0, 0, 32'h0,   2'd0, 1, 64'd0,                1);
        add("unk_type", 8'd9,  8'd2, 2, 32'h0000_0300, 3'd4, 64'd0,                64'd0,                0, 0, 32'h0,   2'd0, 0, 64'd0,                1);
        add("st_len2",  8'd15, 8'd2, 2, 32'h0000_0040, 3'd4, 64'd0,                64'd0,                0, 0, 32'h0,   2'd0, 1, 64'd0,                1);
        add("ld_drain", 8'd14, 8'd4, 4, 32'h0000_0010, 3'd3, 64'd0,                64'h5566778899AABBCC, 1, 0, 32'h010, 2'd2, 1, 64'h99AABBCC99AABBCC, 0);
        add("ld_over",  8'd14, 8'd12,10, 32'h0000_0020, 3'd4, 64'd0,               64'd0,                0, 0, 32'h0,   2'd0, 0, 64'd0,                1);
        add("len0",     8'd14, 8'd0, 0, 32'h0,         3'd0, 64'd0,                64'd0,                0, 0, 32'h0,   2'd0, 0, 64'd0,                1);

        // Reset behaviour
        repeat (3) @(negedge clk);
        chk("rst.outputs", {61'd0, noc_in_rdy, noc_out_val, busy_o}, 64'd0);
        chk("rst.buf", {58'd0, buf_ce_o, buf_we_o, buf_data_sz_o, 2'd0} | 64'(buf_addr_o) | buf_data_o | noc_out_data, 64'd0);
        rst = 1'b0;
        #1;
        chk("rst.rdy_after", 64'(noc_in_rdy), 64'd1);
        chk("rst.busy_after", 64'(busy_o), 64'd0);
`ifdef VORTEX_NOC2BUF_ERRCNT_EN
        chk("rst.errcnt", 64'(err_cnt), 64'd0);
`endif

        foreach (vq[i]) run_vec(vq[i]);

        // Load held off by noc_out_rdy low for 10 cycles
        v = vq[1];
        v.name = "hold"; v.addr = 32'h0000_0004; v.size = 3'd3; v.mshr = 8'h33;
        v.rword = 64'h89ABCDEF01234567;
        buf_data_i  = v.rword;
        noc_out_rdy = 1'b0;
        send_pkt(v, ok);
        noc_in_val = 1'b0;
        chk("hold.accept", 64'(ok), 64'd1);
        for (int c = 0; c < 40 && !noc_out_val; c++) @(negedge clk);
        chk("hold.val", 64'(noc_out_val), 64'd1);
        h0 = noc_out_data;
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!noc_out_val || noc_out_data !== h0 || noc_in_rdy) stable = 1'b0;
        end
        chk("hold.stable", 64'(stable), 64'd1);
        chk("hold.hdr", h0, exp_hdr(v));
        noc_out_rdy = 1'b1;
        @(negedge clk);
        chk("hold.data", noc_out_data, 64'h89ABCDEF89ABCDEF);
        @(negedge clk);
        chk("hold.idle", 64'(noc_out_val), 64'd0);

        // Asynchronous reset while waiting for store data
        v = vq[0];
        send_flit(hdr_flit(v), ok);
        send_flit(flit_of(v, 0), ok);
        send_flit(flit_of(v, 1), ok);
        chk("mid_rst.busy_before", 64'(busy_o), 64'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst.ctrl", {59'd0, noc_in_rdy, noc_out_val, buf_ce_o, buf_we_o, busy_o}, 64'd0);
        chk("mid_rst.buf", 64'(buf_addr_o) | buf_data_o | noc_out_data | 64'(buf_data_sz_o), 64'd0);
        noc_in_val = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst.rdy_after", 64'(noc_in_rdy), 64'd1);
        v = vq[1];
        v.name = "post_rst_ld";
        run_vec(v);

        // Back-to-back load then store with valid held high
        noc_out_rdy = 1'b1;
        buf_data_i  = vq[1].rword;
        @(negedge clk);
        fork
            begin
                bit a, b;
                send_pkt(vq[1], a);
                send_pkt(vq[0], b);
                noc_in_val = 1'b0;
                chk("b2b.accept", 64'(a & b), 64'd1);
            end
            begin
                for (int c = 0; c < 80; c++) begin
                    if (buf_ce_o) ce_we.push_back(int'(buf_we_o));
                    if (noc_out_val) outs.push_back(noc_out_data);
                    @(negedge clk);
                end
            end
        join
        chk("b2b.ce_count", 64'(ce_we.size()), 64'd2);
        if (ce_we.size() == 2) begin
            chk("b2b.ce0_we", 64'(ce_we[0]), 64'd0);
            chk("b2b.ce1_we", 64'(ce_we[1]), 64'd1);
        end
        chk("b2b.out_count", 64'(outs.size()), 64'd3);
        if (outs.size() == 3) begin
            chk("b2b.ld_hdr", outs[0], exp_hdr(vq[1]));
            chk("b2b.ld_data", outs[1], 64'hABABABABABABABAB);
            chk("b2b.st_hdr", outs[2], exp_hdr(vq[0]));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
